rcc_vcore_scan_mon: RTL and testbench

- Parametrised successor to the VCORE scan-increment merge logic. Observes NCH scan/debug signals, such as nrst_out, mco1, mco2 and pll_src_clk.
- For each channel it synchronises the signal, detects rising edges, and keeps a sticky flag and a saturating edge counter.
- Captured data is OR-merged into the VCORE read-data path through a registered read handshake.
- Sits between the RCC register file read mux (mdata) and the bus read-data return (wdata).

---
 rtl/rcc_scan_mon_pkg.sv | 14 +
 rtl/rcc_scan_sync_edge.sv | 30 +++
 rtl/rcc_vcore_scan_mon.sv | 91 +++++++++
 tb/tb_rcc_vcore_scan_mon.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rcc_scan_mon_pkg.sv
// rtl/rcc_scan_mon_pkg.sv - shared constants and helpers for the VCORE scan monitor
package rcc_scan_mon_pkg;

  localparam int STS_STICKY_LSB = 0;
  localparam int STS_LVL_LSB    = 16;
  localparam int STS_SAT_BIT    = 31;
  localparam int RD_SEL_STATUS  = 0;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    if (val >= max) return val;
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/rcc_scan_sync_edge.sv
// rtl/rcc_scan_sync_edge.sv - one-channel synchroniser with rising-edge detect
module rcc_scan_sync_edge
  import rcc_scan_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= lvl;
    end
  end

  assign lvl  = sync[SYNC_STAGES-1];
  assign rise = lvl & ~prev;

endmodule

// File: rtl/rcc_vcore_scan_mon.sv
// rtl/rcc_vcore_scan_mon.sv - scan/debug edge monitor OR-merged into VCORE read data; optional IRQ via RCC_SCAN_MON_IRQ_EN
module rcc_vcore_scan_mon
  import rcc_scan_mon_pkg::*;
#(
  parameter int DW          = 32,
  parameter int NCH         = 4,
  parameter int CW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AW_SEL      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    scan_in,
  input  logic [DW-1:0]     mdata,
  input  logic              rd_req,
  input  logic [AW_SEL-1:0] rd_sel,
  input  logic              rd_clr,
`ifdef RCC_SCAN_MON_IRQ_EN
  input  logic [NCH-1:0]    irq_mask,
  output logic              irq,
`endif
  output logic [DW-1:0]     wdata,
  output logic              rd_ack
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [NCH-1:0] lvl;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] sticky;
  logic [NCH-1:0] sat;
  logic [CW-1:0]  cnt [NCH];
  logic [DW-1:0]  group;
  logic           clr_req;
  logic           clr_sts;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    rcc_scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (scan_in[g]),
      .lvl  (lvl[g]),
      .rise (rise[g])
    );
    assign sat[g] = (cnt[g] == CNT_MAX);
  end

  assign clr_req = rd_req & rd_clr;
  assign clr_sts = clr_req && (rd_sel == AW_SEL'(RD_SEL_STATUS));

  always_comb begin
    group = '0;
    if (rd_sel == AW_SEL'(RD_SEL_STATUS)) begin
      group[STS_STICKY_LSB +: NCH] = sticky;
      group[STS_LVL_LSB +: NCH]    = lvl;
      group[STS_SAT_BIT]           = |sat;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (rd_sel == AW_SEL'(k + 1)) group = DW'(cnt[k]);
      end
    end
  end

  // A rise coinciding with a clear wins, so the edge is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= '0;
      wdata  <= '0;
      rd_ack <= 1'b0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      sticky <= rise | (sticky & ~{NCH{clr_sts}});
      for (int i = 0; i < NCH; i++) begin
        if (clr_req && (rd_sel == AW_SEL'(i + 1)))
          cnt[i] <= rise[i] ? CW'(1) : '0;
        else if (rise[i])
          cnt[i] <= CW'(sat_inc(32'(cnt[i]), 32'(CNT_MAX)));
      end
      wdata  <= mdata | (rd_req ? group : '0);
      rd_ack <= rd_req;
    end
  end

`ifdef RCC_SCAN_MON_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(sticky & irq_mask);
  end
`endif

endmodule

// File: tb/tb_rcc_vcore_scan_mon.sv
// tb/tb_rcc_vcore_scan_mon.sv - scoreboard bench for rcc_vcore_scan_mon
module tb_rcc_vcore_scan_mon;

  localparam int NCH = 4;
  localparam int CW  = 4;

  typedef struct {
    logic [31:0] data;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  scan_in;
  logic [31:0] mdata;
  logic        rd_req;
  logic [4:0]  rd_sel;
  logic        rd_clr;
  logic [31:0] wdata;
  logic        rd_ack;
`ifdef RCC_SCAN_MON_IRQ_EN
  logic [3:0]  irq_mask;
  logic        irq;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rcc_vcore_scan_mon #(
    .DW(32), .NCH(NCH), .CW(CW), .SYNC_STAGES(2), .AW_SEL(5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .scan_in (scan_in),
    .mdata   (mdata),
    .rd_req  (rd_req),
    .rd_sel  (rd_sel),
    .rd_clr  (rd_clr),
`ifdef RCC_SCAN_MON_IRQ_EN
    .irq_mask(irq_mask),
    .irq     (irq),
`endif
    .wdata   (wdata),
    .rd_ack  (rd_ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack with data %h expected no ack", wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, wdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] sel, input logic clr, input logic [31:0] md,
                    input logic [31:0] exp, input string nm);
    exp_t e;
    rd_req = 1'b1;
    rd_sel = sel;
    rd_clr = clr;
    mdata  = md;
    e.data = exp;
    e.name = nm;
    exp_q.push_back(e);
    step();
  endtask

  task automatic idle(input int n);
    rd_req = 1'b0;
    rd_clr = 1'b0;
    rd_sel = '0;
    mdata  = '0;
    repeat (n) step();
  endtask

  task automatic pulse(input int ch, input int n);
    for (int p = 0; p < n; p++) begin
      scan_in[ch] = 1'b1;
      repeat (2) step();
      scan_in[ch] = 1'b0;
      repeat (2) step();
    end
  endtask

  initial begin
    rst     = 1'b1;
    scan_in = '0;
    mdata   = 32'hFFFF_FFFF;
    rd_req  = 1'b0;
    rd_sel  = '0;
    rd_clr  = 1'b0;
`ifdef RCC_SCAN_MON_IRQ_EN
    irq_mask = '0;
`endif
    repeat (3) step();
    chk("reset_wdata", wdata, 32'h0);
    chk("reset_ack", {31'h0, rd_ack}, 32'h0);
    rst = 1'b0;
    mdata = 32'hA5A5_0000;
    step();
    chk("idle_wdata", wdata, 32'hA5A5_0000);
    chk("idle_ack", {31'h0, rd_ack}, 32'h0);
    rd(5'd0, 1'b0, 32'h0, 32'h0, "reset_status");
    for (int k = 1; k <= NCH; k++) rd(5'(k), 1'b0, 32'h0, 32'h0, "reset_cnt");
    idle(2);

    pulse(2, 3);
    idle(4);
    rd(5'd3, 1'b0, 32'h0, 32'h3, "ch2_cnt");
    rd(5'd0, 1'b0, 32'h0, 32'h4, "ch2_status");
    idle(2);

    pulse(0, 20);
    idle(4);
    rd(5'd0, 1'b0, 32'h0, 32'h8000_0005, "sat_status");
    rd(5'd1, 1'b1, 32'h0, 32'hF, "sat_cnt_clr");
    rd(5'd1, 1'b0, 32'h0, 32'h0, "cnt_after_clr");
    rd(5'd0, 1'b0, 32'h0, 32'h5, "status_after_cnt_clr");
    idle(2);

    // Rise on ch1 reaches the flops in the same cycle the status clear is sampled.
    scan_in[1] = 1'b1;
    step();
    step();
    rd(5'd0, 1'b1, 32'h0, 32'h0002_0005, "clr_race_preclear");
    idle(1);
    rd(5'd0, 1'b0, 32'h0, 32'h0002_0002, "clr_race_after");
    scan_in[1] = 1'b0;
    idle(4);

    rd(5'd6, 1'b0, 32'h0000_00FF, 32'h0000_00FF, "oob_sel");
    rd(5'd2, 1'b0, 32'h0000_0100, 32'h0000_0101, "b2b_cnt1");
    rd(5'd0, 1'b0, 32'h1000_0000, 32'h1000_0002, "b2b_status");
    idle(2);

`ifdef RCC_SCAN_MON_IRQ_EN
    irq_mask = 4'b0100;
    idle(2);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    pulse(2, 1);
    idle(3);
    chk("irq_set", {31'h0, irq}, 32'h1);
    rd(5'd0, 1'b1, 32'h0, 32'h6, "irq_status_clr");
    chk("irq_hold", {31'h0, irq}, 32'h1);
    idle(1);
    chk("irq_clear", {31'h0, irq}, 32'h0);
    idle(2);
`endif

    rd_req = 1'b1;
    rd_sel = 5'd0;
    mdata  = 32'hFFFF_FFFF;
    rst    = 1'b1;
    step();
    chk("midrst_ack", {31'h0, rd_ack}, 32'h0);
    chk("midrst_wdata", wdata, 32'h0);
    rst = 1'b0;
    idle(1);
    rd(5'd3, 1'b0, 32'h0, 32'h0, "cnt_after_rst");
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_ack: got %0d pending reads expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
